// File: rtl/ema_pkg.sv
// ema_pkg: shared types and helpers for the EMA step-response monitor.
// Contents: monitor state enum, default sample width, abs_diff helper.
// Latency/backpressure: n/a (declarations only).
package ema_pkg;

  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEAS   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Magnitude of the difference of two unsigned values. Operands are
  // widened to 32 bits by the caller, so the result never wraps.
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/ema_settle_monitor_if.sv
// ema_settle_monitor_if: sample bus from the EMA filter plus the monitor's
// result bus. master = sample source (filter side), slave = monitor.
// Ports: sample_valid/x_in/y_in toward the monitor; busy, meas_valid,
// settle_cycles, overshoot, step_up, timeout back from it. No backpressure.
interface ema_settle_monitor_if
  import ema_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 16
) ();

  logic              sample_valid;
  logic [DATA_W-1:0] x_in;
  logic [DATA_W-1:0] y_in;
  logic              busy;
  logic              meas_valid;
  logic [CNT_W-1:0]  settle_cycles;
  logic [DATA_W-1:0] overshoot;
  logic              step_up;
  logic              timeout;

  modport master (
    output sample_valid, x_in, y_in,
    input  busy, meas_valid, settle_cycles, overshoot, step_up, timeout
  );

  modport slave (
    input  sample_valid, x_in, y_in,
    output busy, meas_valid, settle_cycles, overshoot, step_up, timeout
  );

endinterface

// File: rtl/ema_band_check.sv
// ema_band_check: in-band flag (|x - y| <= TOL) and signed excursion y - x.
// Latency: purely combinational. Backpressure: none.
// Ports: i_x, i_y samples in; o_in_band, o_exc (DATA_W+1 bits signed) out.
module ema_band_check
  import ema_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TOL    = 2
) (
  input  logic [DATA_W-1:0]      i_x,
  input  logic [DATA_W-1:0]      i_y,
  output logic                   o_in_band,
  output logic signed [DATA_W:0] o_exc
);

  logic [31:0] w_mag;

  // One extra bit keeps the signed difference of two unsigned samples exact.
  assign o_exc     = $signed({1'b0, i_y}) - $signed({1'b0, i_x});
  assign w_mag     = abs_diff(32'(i_x), 32'(i_y));
  assign o_in_band = (w_mag <= 32'(TOL));

endmodule

// File: rtl/ema_settle_monitor.sv
// ema_settle_monitor: detects steps on x_in and measures how many samples
// y_in needs to settle within +/-TOL for HOLD samples, plus peak overshoot.
// Latency: meas_valid one cycle after the deciding sample; no backpressure,
// one sample per cycle. Optional macro EMA_MON_OVERSHOOT_EN builds overshoot
// tracking; without it overshoot reads 0.
// Ports: clk, reset (async active-low), mon (slave side of the bus).
module ema_settle_monitor
  import ema_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 16,
  parameter int TOL    = 2,
  parameter int HOLD   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  ema_settle_monitor_if.slave  mon
);

  localparam int RUN_W = $clog2(HOLD + 1);

  state_t                  r_state, w_state_nxt;
  logic                    r_primed;
  logic [DATA_W-1:0]       r_x_prev;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]        r_start, w_start_nxt;
  logic [RUN_W-1:0]        r_run, w_run_nxt;
  logic                    r_up, w_up_nxt;
  logic                    w_step, w_proc, w_fire, w_fire_to;
  logic                    w_in_band;
  logic signed [DATA_W:0]  w_exc;
  logic [DATA_W-1:0]       w_ovs_upd;

  logic                    r_busy;
  logic                    r_meas_valid;
  logic [CNT_W-1:0]        r_settle;
  logic [DATA_W-1:0]       r_overshoot;
  logic                    r_step_up;
  logic                    r_timeout;

  ema_band_check #(
    .DATA_W (DATA_W),
    .TOL    (TOL)
  ) u_band (
    .i_x       (mon.x_in),
    .i_y       (mon.y_in),
    .o_in_band (w_in_band),
    .o_exc     (w_exc)
  );

  // A step needs a primed x_prev; the priming sample itself never counts.
  assign w_step = mon.sample_valid && r_primed && (mon.x_in != r_x_prev);
  // Non-step samples that advance an active measurement.
  assign w_proc = mon.sample_valid && !w_step &&
                  ((r_state == MEAS) || (r_state == SETTLE));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start_nxt = r_start;
    w_run_nxt   = r_run;
    w_up_nxt    = r_up;
    w_fire      = 1'b0;
    w_fire_to   = 1'b0;
    if (w_step) begin
      // A step in any state (re)starts a measurement at index 0.
      w_state_nxt = MEAS;
      w_cnt_nxt   = '0;
      w_run_nxt   = '0;
      w_up_nxt    = (mon.x_in > r_x_prev);
    end else if (w_proc) begin
      w_cnt_nxt = r_cnt + 1'b1;
      if (w_in_band) begin
        if (r_state == MEAS) begin
          w_start_nxt = w_cnt_nxt;
          w_run_nxt   = RUN_W'(1);
          w_state_nxt = SETTLE;
        end else begin
          w_run_nxt = r_run + 1'b1;
        end
      end else begin
        w_run_nxt   = '0;
        w_state_nxt = MEAS;
      end
      // Completing the hold run wins over saturation on the same sample.
      if (w_in_band && (w_run_nxt == RUN_W'(HOLD))) begin
        w_fire      = 1'b1;
        w_state_nxt = DONE;
      end else if (&w_cnt_nxt) begin
        w_fire      = 1'b1;
        w_fire_to   = 1'b1;
        w_state_nxt = DONE;
      end
    end else if (r_state == DONE) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_primed     <= 1'b0;
      r_x_prev     <= '0;
      r_cnt        <= '0;
      r_start      <= '0;
      r_run        <= '0;
      r_up         <= 1'b0;
      r_busy       <= 1'b0;
      r_meas_valid <= 1'b0;
      r_settle     <= '0;
      r_overshoot  <= '0;
      r_step_up    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      if (mon.sample_valid) begin
        r_primed <= 1'b1;
        r_x_prev <= mon.x_in;
      end
      r_cnt        <= w_cnt_nxt;
      r_start      <= w_start_nxt;
      r_run        <= w_run_nxt;
      r_up         <= w_up_nxt;
      // DONE counts as busy, so busy covers the meas_valid cycle.
      r_busy       <= (w_state_nxt != IDLE);
      r_meas_valid <= w_fire;
      if (w_fire) begin
        r_settle    <= w_fire_to ? {CNT_W{1'b1}} : w_start_nxt;
        r_timeout   <= w_fire_to;
        r_step_up   <= r_up;
        r_overshoot <= w_ovs_upd;
      end
    end
  end

`ifdef EMA_MON_OVERSHOOT_EN
  logic [DATA_W-1:0]      r_ovs;
  logic signed [DATA_W:0] w_cand;

  // Excursion measured in the step direction; a non-positive value never
  // beats r_ovs (which is >= 0), so only real overshoot is kept.
  always_comb begin
    w_cand    = r_up ? w_exc : -w_exc;
    w_ovs_upd = r_ovs;
    if (w_cand > $signed({1'b0, r_ovs})) begin
      w_ovs_upd = w_cand[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovs <= '0;
    end else if (w_step) begin
      r_ovs <= '0;
    end else if (w_proc) begin
      r_ovs <= w_ovs_upd;
    end
  end
`else
  logic w_exc_unused;
  assign w_exc_unused = ^w_exc;
  assign w_ovs_upd    = '0;
`endif

  assign mon.busy          = r_busy;
  assign mon.meas_valid    = r_meas_valid;
  assign mon.settle_cycles = r_settle;
  assign mon.overshoot     = r_overshoot;
  assign mon.step_up       = r_step_up;
  assign mon.timeout       = r_timeout;

endmodule

// File: tb/tb_ema_settle_monitor.sv
// tb_ema_settle_monitor: directed checks of the step-response monitor.
// Main instance uses CNT_W=16; a second CNT_W=4 instance covers saturation.
// Inputs driven on the falling edge, outputs checked on the falling edge.
module tb_ema_settle_monitor;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;

`ifdef EMA_MON_OVERSHOOT_EN
  localparam int OVS_ON = 1;
`else
  localparam int OVS_ON = 0;
`endif

  ema_settle_monitor_if #(.DATA_W(8), .CNT_W(16)) ifc ();
  ema_settle_monitor_if #(.DATA_W(8), .CNT_W(4))  ifc4 ();

  ema_settle_monitor #(.DATA_W(8), .CNT_W(16), .TOL(2), .HOLD(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .mon   (ifc.slave)
  );

  ema_settle_monitor #(.DATA_W(8), .CNT_W(4), .TOL(2), .HOLD(4)) dut4 (
    .clk   (clk),
    .reset (rst_n),
    .mon   (ifc4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifc.meas_valid === 1'b1) pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic smp(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    ifc.sample_valid = 1'b1;
    ifc.x_in         = x;
    ifc.y_in         = y;
  endtask

  task automatic smp4(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    ifc4.sample_valid = 1'b1;
    ifc4.x_in         = x;
    ifc4.y_in         = y;
  endtask

  task automatic idle();
    @(negedge clk);
    ifc.sample_valid  = 1'b0;
    ifc4.sample_valid = 1'b0;
  endtask

  // Called in the cycle where a result pulse is expected.
  task automatic chk_res(input string tag, input int settle, input int up,
                         input int ovs, input int to);
    chk({tag, ".meas_valid"},    32'(ifc.meas_valid),    1);
    chk({tag, ".busy"},          32'(ifc.busy),          1);
    chk({tag, ".settle_cycles"}, 32'(ifc.settle_cycles), settle);
    chk({tag, ".step_up"},       32'(ifc.step_up),       up);
    chk({tag, ".overshoot"},     32'(ifc.overshoot),     ovs);
    chk({tag, ".timeout"},       32'(ifc.timeout),       to);
  endtask

  initial begin
    rst_n             = 1'b0;
    ifc.sample_valid  = 1'b0;
    ifc.x_in          = '0;
    ifc.y_in          = '0;
    ifc4.sample_valid = 1'b0;
    ifc4.x_in         = '0;
    ifc4.y_in         = '0;
    idle();
    idle();
    chk("reset.busy",       32'(ifc.busy),          0);
    chk("reset.meas_valid", 32'(ifc.meas_valid),    0);
    chk("reset.settle",     32'(ifc.settle_cycles), 0);
    chk("reset.overshoot",  32'(ifc.overshoot),     0);
    chk("reset.step_up",    32'(ifc.step_up),       0);
    chk("reset.timeout",    32'(ifc.timeout),       0);
    rst_n = 1'b1;

    // Clean upward step: first in-band run starts at index 4.
    smp(50, 50);
    smp(200, 50);
    chk("clean.busy_before", 32'(ifc.busy), 0);
    smp(200, 100);
    chk("clean.busy_after_step", 32'(ifc.busy), 1);
    smp(200, 150); smp(200, 190); smp(200, 198);
    smp(200, 199); smp(200, 200); smp(200, 200);
    idle();
    chk_res("clean", 4, 1, 0, 0);
    idle();
    chk("clean.pulse_width", 32'(ifc.meas_valid), 0);
    chk("clean.busy_end",    32'(ifc.busy),       0);
    chk("clean.pulses",      32'(pulses),         1);

    // Overshoot: 205 overshoots a 200 target by 5; 50-sample step is abandoned.
    smp(50, 50);
    smp(200, 50); smp(200, 150); smp(200, 205); smp(200, 201);
    smp(200, 200); smp(200, 200); smp(200, 200);
    idle();
    chk_res("ovs", 3, 1, (OVS_ON != 0) ? 5 : 0, 0);
    idle();
    chk("ovs.pulses", 32'(pulses), 2);

    // Broken run on a downward step: 30 breaks the run started at index 1.
    smp(20, 200); smp(20, 21); smp(20, 22); smp(20, 30);
    smp(20, 20); smp(20, 20); smp(20, 20); smp(20, 20);
    idle();
    chk_res("broken", 4, 0, 0, 0);
    idle();
    chk("broken.pulses", 32'(pulses), 3);

    // Restart: upward step abandoned after 3 samples by a step down to 20.
    smp(50, 50);
    smp(200, 50); smp(200, 60); smp(200, 70); smp(200, 80);
    smp(20, 80); smp(20, 60); smp(20, 40); smp(20, 21);
    chk("restart.no_pulse", 32'(pulses), 3);
    chk("restart.busy",     32'(ifc.busy), 1);
    smp(20, 20); smp(20, 19); smp(20, 20);
    idle();
    chk_res("restart", 3, 0, (OVS_ON != 0) ? 1 : 0, 0);
    idle();
    chk("restart.pulses", 32'(pulses), 4);

    // Clean step again with sample_valid gaps sprinkled in.
    smp(50, 50);
    smp(200, 50); idle(); smp(200, 100); idle(); idle();
    chk("gaps.busy_in_gap", 32'(ifc.busy), 1);
    smp(200, 150); smp(200, 190); idle(); smp(200, 198); smp(200, 199);
    idle(); smp(200, 200); smp(200, 200);
    idle();
    chk_res("gaps", 4, 1, 0, 0);
    idle();
    chk("gaps.pulses", 32'(pulses), 5);

    // Reset during SETTLE: no pulse, all outputs cleared, re-prime after.
    smp(20, 200); smp(20, 20); smp(20, 20);
    @(negedge clk);
    ifc.sample_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst.busy",      32'(ifc.busy),          0);
    chk("rst.settle",    32'(ifc.settle_cycles), 0);
    chk("rst.step_up",   32'(ifc.step_up),       0);
    rst_n = 1'b1;
    smp(50, 50);
    smp(50, 50); smp(50, 50);
    idle();
    chk("rst.reprime_busy", 32'(ifc.busy), 0);
    idle();
    chk("rst.pulses", 32'(pulses), 5);

    // Saturation on the CNT_W=4 instance: pulse 15 samples after the step.
    smp4(0, 0);
    smp4(200, 0);
    for (int i = 1; i <= 15; i++) begin
      smp4(200, 0);
      if (i == 15) chk("to.no_early_pulse", 32'(ifc4.meas_valid), 0);
    end
    idle();
    chk("to.meas_valid", 32'(ifc4.meas_valid),    1);
    chk("to.timeout",    32'(ifc4.timeout),       1);
    chk("to.settle",     32'(ifc4.settle_cycles), 15);
    chk("to.step_up",    32'(ifc4.step_up),       1);
    chk("to.overshoot",  32'(ifc4.overshoot),     0);
    idle();
    chk("to.pulse_width", 32'(ifc4.meas_valid), 0);
    chk("to.busy_end",    32'(ifc4.busy),       0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ema_settle_monitor.md
# ema_settle_monitor

Hardware step-response monitor for the EMA filter output. It observes the filter's input `x_in` and output `y_in` on each valid sample and detects step changes on `x_in`. It then measures how many samples `y_in` takes to settle inside a tolerance band and reports the peak overshoot. It sits downstream of the filter as the on-chip reader of the filter interface, so the filter can be characterised in silicon without a simulator.

## Interface
- `DATA_W`, 8: sample width of `x_in` and `y_in`.
- `CNT_W`, 16: settle-counter width.
- `TOL`, 2: settle band; a sample is in band when |x_in − y_in| ≤ TOL.
- `HOLD`, 4: number of consecutive in-band samples required to declare settled (≥1).

- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sample_valid`  in  1  qualifies `x_in` and `y_in` for this cycle.
- `x_in`  in  DATA_W  filter input (target value), unsigned.
- `y_in`  in  DATA_W  filter output, unsigned.
- `busy`  out  1  a measurement is in progress.
- `meas_valid`  out  1  one-cycle pulse; the result outputs are valid.
- `settle_cycles`  out  CNT_W  index of the first sample of the final in-band run; the step sample is index 0.
- `overshoot`  out  DATA_W  peak excursion of `y_in` beyond the target, in the direction of the step.
- `step_up`  out  1  1 when the step that was measured went upward.
- `timeout`  out  1  the result ended because the counter saturated.

## Operation
- **Samples:** only cycles with `sample_valid` = 1 are samples; all other cycles are ignored entirely (no count, no state change).
- **Priming:** the first sample after reset loads `x_prev` and does not count as a step.
- **Step detection:** a step is a sample where `x_in` ≠ `x_prev`. `x_prev` updates on every sample.
- **State machine:**
  - IDLE → MEAS on a step. On entry: count = 0, `step_up` = (x_in > x_prev), overshoot = 0, run = 0.
  - MEAS: the count increments on every sample after the step sample.
    - An in-band sample records `start` = count and sets run = 1, then goes to SETTLE. If HOLD = 1, it goes straight to DONE.
  - SETTLE:
    - An in-band sample increments run; when run reaches HOLD, go to DONE.
    - An out-of-band sample clears run and returns to MEAS.
  - DONE: pulses `meas_valid` with `settle_cycles` = `start` and `timeout` = 0, then returns to IDLE.
- **New step during MEAS or SETTLE:** the current measurement is abandoned with no `meas_valid`, and a new measurement restarts from the step sample.
- **Timeout:** if the count reaches 2^CNT_W − 1 while in MEAS or SETTLE, pulse `meas_valid` with `timeout` = 1 and `settle_cycles` all ones, then go to IDLE.
- **Overshoot:** every sample in MEAS or SETTLE updates overshoot = max(overshoot, y_in − x_in) when `step_up`, or max(overshoot, x_in − y_in) when not. Only positive excursions count.
- **Arithmetic:** differences are computed at DATA_W+1 bits, signed; no wrap-around is allowed.
- **Output hold:** result outputs hold their value until the next `meas_valid`.

## Timing
- Reset: state IDLE, unprimed; every output is 0.
- `meas_valid` is registered. It goes high in the cycle after the clock edge that samples the HOLD-th in-band sample (or the saturating sample), and stays high for exactly one cycle.
- `busy` is registered: high from the cycle after the step sample until the cycle `meas_valid` is high, inclusive.
- Reset asserted mid-measurement aborts immediately with no pulse. The first sample after reset release re-primes `x_prev`.
- Throughput is one sample per cycle. Back-to-back steps are allowed.

## Configuration
- `EMA_MON_OVERSHOOT_EN`
  - Defined: overshoot tracking is built as described above.
  - Undefined: the tracking logic is omitted and `overshoot` is tied to 0. The port list is unchanged.

## Structure
- Package `ema_pkg` holds:
  - the state enum (IDLE, MEAS, SETTLE, DONE);
  - the default `DATA_W`;
  - an `abs_diff` function.
- Sub-module `ema_band_check` (combinational) produces the in-band flag and the signed excursion from `x_in`, `y_in` and `TOL`.

## Test plan
Defaults are TOL = 2 and HOLD = 4 unless noted.
- **Clean step:** prime with x = 50, y = 50; x = 200 with y = 50, 100, 150, 190, 198, 199, 200, 200 → one `meas_valid`, `settle_cycles` = 4, `step_up` = 1, `overshoot` = 0.
- **Overshoot:** x = 50 → 200 with y = 50, 150, 205, 201, 200, 200, 200 → `settle_cycles` = 3, `overshoot` = 5; with the macro undefined, `overshoot` = 0.
- **Broken run:** x = 200 → 20 with y = 200, 21, 22, 30, 20, 20, 20, 20 → the run breaks at 30, giving `settle_cycles` = 4 and `step_up` = 0.
- **Step restart:** x = 50 → 200, then x = 20 after 3 samples → no pulse for the first step; the result is referenced to the x = 20 step sample.
- **Timeout:** CNT_W = 4 with y held at 0 and x = 200 after the step → a pulse 15 samples after the step with `timeout` = 1 and `settle_cycles` = 15.
- **Reset and gaps:** `reset` low during SETTLE gives all outputs 0 and no pulse. `sample_valid` gaps inserted into the clean-step test leave the result unchanged.
